multi_blinker: RTL and testbench

//  N-channel blinking-light controller, successor of the single-channel blinker FSM.

---
 rtl/blinker_pkg.sv | 16 +
 rtl/blink_channel.sv | 111 +++++++++++
 rtl/multi_blinker.sv | 45 ++++
 tb/tb_multi_blinker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blinker_pkg.sv
// rtl/blinker_pkg.sv - shared types and default parameters for the multi-channel blinker
package blinker_pkg;

    // One-hot per-channel state encoding
    typedef enum logic [3:0] {
        START = 4'b0001,
        STOP  = 4'b0010,
        ON    = 4'b0100,
        OFF   = 4'b1000
    } blink_state_t;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_W       = 26;
    localparam int DEF_STARTUP_CYC = 50_000_000;

endpackage

// File: rtl/blink_channel.sv
// rtl/blink_channel.sv - one blinking-light channel: state machine, phase timer and duration latch
module blink_channel
    import blinker_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int STARTUP_CYC = DEF_STARTUP_CYC
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             sync_i,
    input  logic [CNT_W-1:0] t_on_i,
    input  logic [CNT_W-1:0] t_off_i,
    output logic             light_o,
    output logic             phase_o
);

    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYC - 1);

    blink_state_t     state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] on_dur, off_dur;

    // A zero duration is stretched to one cycle so no phase is ever skipped
    assign on_dur  = (t_on_i  == '0) ? ONE : t_on_i;
    assign off_dur = (t_off_i == '0) ? ONE : t_off_i;

    // State, timer, latched duration and phase marker registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= START;
            timer_q <= '0;
            dur_q   <= ONE;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dur_q   <= dur_d;
            phase_q <= phase_d;
        end
    end

    // Next-state logic: enable low beats sync, sync beats the phase timer
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + ONE;
        dur_d   = dur_q;
        phase_d = 1'b0;
        case (state_q)
            START: begin
                if (timer_q == STARTUP_LAST) begin
                    timer_d = '0;
                    if (enable_i) begin
                        state_d = ON;
                        dur_d   = on_dur;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // timer is held at zero while stopped
                timer_d = '0;
                if (enable_i) begin
                    state_d = ON;
                    dur_d   = on_dur;
                    phase_d = sync_i;
                end
            end
            ON: begin
                if (!enable_i) begin
                    state_d = STOP;
                    timer_d = '0;
                end else if (sync_i) begin
                    timer_d = '0;
                    dur_d   = on_dur;
                    phase_d = 1'b1;
                end else if (timer_q == dur_q - ONE) begin
                    state_d = OFF;
                    timer_d = '0;
                    dur_d   = off_dur;
                end
            end
            OFF: begin
                if (!enable_i) begin
                    state_d = STOP;
                    timer_d = '0;
                end else if (sync_i || (timer_q == dur_q - ONE)) begin
                    state_d = ON;
                    timer_d = '0;
                    dur_d   = on_dur;
                    phase_d = 1'b1;
                end
            end
            default: begin
                state_d = START;
                timer_d = '0;
            end
        endcase
    end

    // Outputs: light during start-up hold and ON, phase marker from its register
    always_comb begin
        light_o = (state_q == START) || (state_q == ON);
        phase_o = phase_q;
    end

endmodule

// File: rtl/multi_blinker.sv
// rtl/multi_blinker.sv - N-channel blinker top; optional BLINKER_SYNC_EN adds sync_i phase alignment
module multi_blinker
    import blinker_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int STARTUP_CYC = DEF_STARTUP_CYC
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
`ifdef BLINKER_SYNC_EN
    input  logic                    sync_i,
`endif
    input  logic [NUM_CH-1:0]       enable_i,
    input  logic [NUM_CH*CNT_W-1:0] t_on_i,
    input  logic [NUM_CH*CNT_W-1:0] t_off_i,
    output logic [NUM_CH-1:0]       light_o,
    output logic [NUM_CH-1:0]       phase_o
);

    logic sync_w;

`ifdef BLINKER_SYNC_EN
    assign sync_w = sync_i;
`else
    assign sync_w = 1'b0;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        blink_channel #(
            .CNT_W       (CNT_W),
            .STARTUP_CYC (STARTUP_CYC)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .enable_i (enable_i[k]),
            .sync_i   (sync_w),
            .t_on_i   (t_on_i[k*CNT_W +: CNT_W]),
            .t_off_i  (t_off_i[k*CNT_W +: CNT_W]),
            .light_o  (light_o[k]),
            .phase_o  (phase_o[k])
        );
    end

endmodule

// File: tb/tb_multi_blinker.sv
// tb/tb_multi_blinker.sv - directed self-checking bench for multi_blinker
module tb_multi_blinker;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 8;
    localparam int STARTUP_CYC = 5;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    sync = 1'b0;
    logic [NUM_CH-1:0]       enable = '0;
    logic [NUM_CH*CNT_W-1:0] t_on = '0;
    logic [NUM_CH*CNT_W-1:0] t_off = '0;
    logic [NUM_CH-1:0]       light;
    logic [NUM_CH-1:0]       phase;

    int n_checks = 0;
    int n_fail   = 0;

    multi_blinker #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .STARTUP_CYC (STARTUP_CYC)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
`ifdef BLINKER_SYNC_EN
        .sync_i   (sync),
`endif
        .enable_i (enable),
        .t_on_i   (t_on),
        .t_off_i  (t_off),
        .light_o  (light),
        .phase_o  (phase)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reset, release at a falling edge (sample S0), then wait to sample S5
    task automatic reset_to_s5;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [1:0] exp_l;
        enable = 2'b00;
        t_on   = '0;
        t_off  = '0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (light !== 2'b11) begin
            $display("FAIL reset_light actual=%b expected=%b", light, 2'b11);
            n_fail++;
        end
        n_checks++;
        if (phase !== 2'b00) begin
            $display("FAIL reset_phase actual=%b expected=%b", phase, 2'b00);
            n_fail++;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_l = (i < 5) ? 2'b11 : 2'b00;
            n_checks++;
            if (light !== exp_l) begin
                $display("FAIL startup_light cycle=%0d actual=%b expected=%b", i, light, exp_l);
                n_fail++;
            end
            n_checks++;
            if (phase !== 2'b00) begin
                $display("FAIL startup_phase cycle=%0d actual=%b expected=%b", i, phase, 2'b00);
                n_fail++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blink;
        logic [1:0] exp_l, exp_p;
        enable = 2'b01;
        t_on   = {8'd0, 8'd3};
        t_off  = {8'd0, 8'd2};
        reset_to_s5();
        for (int j = 0; j < 15; j++) begin
            exp_l = {1'b0, (j % 5) < 3};
            exp_p = {1'b0, (j % 5 == 0) && (j != 0)};
            n_checks++;
            if (light !== exp_l) begin
                $display("FAIL blink_light cycle=%0d actual=%b expected=%b", j, light, exp_l);
                n_fail++;
            end
            n_checks++;
            if (phase !== exp_p) begin
                $display("FAIL blink_phase cycle=%0d actual=%b expected=%b", j, phase, exp_p);
                n_fail++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_duration;
        logic [1:0] exp_l, exp_p;
        enable = 2'b01;
        t_on   = '0;
        t_off  = '0;
        reset_to_s5();
        for (int j = 0; j < 10; j++) begin
            exp_l = {1'b0, (j % 2) == 0};
            exp_p = {1'b0, ((j % 2) == 0) && (j != 0)};
            n_checks++;
            if (light !== exp_l) begin
                $display("FAIL zero_dur_light cycle=%0d actual=%b expected=%b", j, light, exp_l);
                n_fail++;
            end
            n_checks++;
            if (phase !== exp_p) begin
                $display("FAIL zero_dur_phase cycle=%0d actual=%b expected=%b", j, phase, exp_p);
                n_fail++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_enable_drop;
        logic [0:9] exp_seq;
        logic [1:0] exp_l, exp_p;
        exp_seq = 10'b1100111001;
        enable  = 2'b01;
        t_on    = {8'd0, 8'd3};
        t_off   = {8'd0, 8'd2};
        reset_to_s5();
        for (int j = 0; j < 10; j++) begin
            exp_l = {1'b0, exp_seq[j]};
            exp_p = {1'b0, j == 9};
            n_checks++;
            if (light !== exp_l) begin
                $display("FAIL enable_drop_light cycle=%0d actual=%b expected=%b", j, light, exp_l);
                n_fail++;
            end
            n_checks++;
            if (phase !== exp_p) begin
                $display("FAIL enable_drop_phase cycle=%0d actual=%b expected=%b", j, phase, exp_p);
                n_fail++;
            end
            if (j == 1) enable = 2'b00;
            if (j == 3) enable = 2'b01;
            @(negedge clk);
        end
    endtask

    task automatic test_duration_change;
        logic [0:13] exp_seq;
        logic [1:0]  exp_l, exp_p;
        exp_seq = 14'b11100111111001;
        enable  = 2'b01;
        t_on    = {8'd0, 8'd3};
        t_off   = {8'd0, 8'd2};
        reset_to_s5();
        for (int j = 0; j < 14; j++) begin
            exp_l = {1'b0, exp_seq[j]};
            exp_p = {1'b0, (j == 5) || (j == 13)};
            n_checks++;
            if (light !== exp_l) begin
                $display("FAIL dur_change_light cycle=%0d actual=%b expected=%b", j, light, exp_l);
                n_fail++;
            end
            n_checks++;
            if (phase !== exp_p) begin
                $display("FAIL dur_change_phase cycle=%0d actual=%b expected=%b", j, phase, exp_p);
                n_fail++;
            end
            if (j == 1) t_on = {8'd0, 8'd6};
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_off;
        logic [1:0] exp_l;
        enable = 2'b01;
        t_on   = {8'd0, 8'd3};
        t_off  = {8'd0, 8'd2};
        reset_to_s5();
        for (int j = 0; j < 4; j++) begin
            exp_l = (j < 3) ? 2'b01 : 2'b00;
            n_checks++;
            if (light !== exp_l) begin
                $display("FAIL pre_reset_light cycle=%0d actual=%b expected=%b", j, light, exp_l);
                n_fail++;
            end
            if (j < 3) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (light !== 2'b11) begin
            $display("FAIL async_reset_light actual=%b expected=%b", light, 2'b11);
            n_fail++;
        end
        n_checks++;
        if (phase !== 2'b00) begin
            $display("FAIL async_reset_phase actual=%b expected=%b", phase, 2'b00);
            n_fail++;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_l = (i < 5) ? 2'b11 : 2'b01;
            n_checks++;
            if (light !== exp_l) begin
                $display("FAIL restart_light cycle=%0d actual=%b expected=%b", i, light, exp_l);
                n_fail++;
            end
            @(negedge clk);
        end
    endtask

`ifdef BLINKER_SYNC_EN
    task automatic test_sync;
        logic [0:4] exp_l1, exp_l0;
        logic [1:0] exp_l, exp_p;
        exp_l0 = 5'b11100;
        exp_l1 = 5'b11110;
        enable = 2'b11;
        t_on   = {8'd4, 8'd3};
        t_off  = {8'd4, 8'd2};
        reset_to_s5();
        repeat (3) @(negedge clk);
        n_checks++;
        if (light !== 2'b10) begin
            $display("FAIL pre_sync_light actual=%b expected=%b", light, 2'b10);
            n_fail++;
        end
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        for (int j = 0; j < 5; j++) begin
            exp_l = {exp_l1[j], exp_l0[j]};
            exp_p = (j == 0) ? 2'b11 : 2'b00;
            n_checks++;
            if (light !== exp_l) begin
                $display("FAIL sync_light cycle=%0d actual=%b expected=%b", j, light, exp_l);
                n_fail++;
            end
            n_checks++;
            if (phase !== exp_p) begin
                $display("FAIL sync_phase cycle=%0d actual=%b expected=%b", j, phase, exp_p);
                n_fail++;
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_blink();
        test_zero_duration();
        test_enable_drop();
        test_duration_change();
        test_reset_mid_off();
`ifdef BLINKER_SYNC_EN
        test_sync();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
